// File: rtl/sr_control.sv
// Serializes a WIDTH-bit word MSB first to an external shift register with clock and load strobe.
// Optional macro SR_LOAD_STROBE_EN enables the load_sr pulse; otherwise load_sr stays 0 with timing unchanged.
module sr_control #(
   parameter int WIDTH     = 170,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     din,
   output logic                 data_out,
   output logic                 clk_sr,
   output logic                 load_sr,
   output logic [CNT_WIDTH-1:0] count_delay
);

   typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD} state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(WIDTH - 1);

   state_t               state, state_n;
   logic [WIDTH-1:0]     sreg;
   logic [CNT_WIDTH-1:0] bit_cnt;
   logic                 last_bit;

   assign last_bit = (bit_cnt == LAST_CNT);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:     if (start) state_n = SHIFT_LO;
         SHIFT_LO: state_n = SHIFT_HI;
         SHIFT_HI: state_n = last_bit ? LOAD : SHIFT_LO;
         LOAD:     state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end

   // Outputs are registered decodes of the current state, so they trail the
   // state by one cycle: the cycle right after start acceptance shows idle outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sreg        <= '0;
         bit_cnt     <= '0;
         data_out    <= 1'b0;
         clk_sr      <= 1'b0;
         load_sr     <= 1'b0;
         count_delay <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (start) begin
                  sreg    <= din;
                  bit_cnt <= '0;
               end
            end
            SHIFT_HI: begin
               sreg    <= {sreg[WIDTH-2:0], 1'b0};
               bit_cnt <= bit_cnt + 1'b1;
            end
            default: ;
         endcase
         data_out    <= ((state == SHIFT_LO) || (state == SHIFT_HI)) & sreg[WIDTH-1];
         clk_sr      <= (state == SHIFT_HI);
         count_delay <= (state == IDLE) ? '0 : bit_cnt;
`ifdef SR_LOAD_STROBE_EN
         load_sr     <= (state == LOAD);
`else
         load_sr     <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_sr_control.sv
// Directed bench for sr_control: table of transfers plus reset and back-to-back sequences.
module tb_sr_control;
   localparam int W  = 170;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  din = '0;
   logic          data_out, clk_sr, load_sr;
   logic [CW-1:0] count_delay;

   int checks = 0;
   int failures = 0;

`ifdef SR_LOAD_STROBE_EN
   localparam int LOAD_EN = 1;
`else
   localparam int LOAD_EN = 0;
`endif

   sr_control #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .din(din),
      .data_out(data_out), .clk_sr(clk_sr), .load_sr(load_sr),
      .count_delay(count_delay)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] din;
      int           busy_at;
      int           rst_at;
      int           exp_edges;
      int           exp_loads;
   } vec_t;

   task automatic chk(input string name, input int k, input logic [CW+2:0] act, input logic [CW+2:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s k=%0d got {d,c,l,cnt}=%b_%b_%b_%0d want %b_%b_%b_%0d", name, k,
                  act[CW+2], act[CW+1], act[CW], act[CW-1:0], exp[CW+2], exp[CW+1], exp[CW], exp[CW-1:0]);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   // Runs one transfer. pre=1: start was already accepted at the previous edge.
   // hold=1: start stays high and dn is presented for the back-to-back transfer.
   task automatic do_xfer(input string name, input logic [W-1:0] d, input int busy_at, input int rst_at,
                          input bit pre, input bit hold, input logic [W-1:0] dn,
                          output int edges, output int loads);
      logic          eb, ec, el;
      logic [CW-1:0] en;
      logic          prev_c;
      int            i;
      edges = 0; loads = 0; prev_c = 1'b0;
      if (!pre) begin
         @(negedge clk); start = 1'b1; din = d;
         @(posedge clk); @(negedge clk);
      end
      if (!hold) start = 1'b0;
      din = ~d;
      chk({name, "_accept"}, 0, {data_out, clk_sr, load_sr, count_delay}, '0);
      for (int k = 1; k <= 2*W+2; k++) begin
         @(posedge clk); @(negedge clk);
         if (k <= 2*W) begin
            i  = (k - 1) / 2;
            eb = d[W-1-i];
            ec = (k % 2 == 0);
            el = 1'b0;
            en = CW'(i);
         end else if (k == 2*W+1) begin
            eb = 1'b0; ec = 1'b0; el = (LOAD_EN != 0); en = CW'(W);
         end else begin
            eb = 1'b0; ec = 1'b0; el = 1'b0; en = '0;
         end
         chk(name, k, {data_out, clk_sr, load_sr, count_delay}, {eb, ec, el, en});
         if (clk_sr && !prev_c) edges++;
         prev_c = clk_sr;
         if (load_sr) loads++;
         if (busy_at >= 0 && k == 2*busy_at+1) start = 1'b1;
         if (busy_at >= 0 && k == 2*busy_at+2) start = 1'b0;
         if (hold && k == 2*W+1) din = dn;
         if (rst_at >= 0 && k == 2*rst_at+1) begin
            rst = 1'b1;
            @(posedge clk); @(negedge clk);
            rst = 1'b0;
            chk({name, "_rst"}, k, {data_out, clk_sr, load_sr, count_delay}, '0);
            for (int j = 0; j < 6; j++) begin
               @(posedge clk); @(negedge clk);
               if (load_sr) loads++;
               chk({name, "_post_rst"}, j, {data_out, clk_sr, load_sr, count_delay}, '0);
            end
            return;
         end
      end
   endtask

   vec_t vecs[4];
   logic [W-1:0] pat;
   int edges, loads;

   initial begin
      pat = '0;
      pat[W-1] = 1'b1;
      pat[3:0] = 4'b1011;
      vecs[0] = '{din: pat, busy_at: -1, rst_at: -1, exp_edges: W, exp_loads: LOAD_EN};
      vecs[1] = '{din: pat, busy_at: 50, rst_at: -1, exp_edges: W, exp_loads: LOAD_EN};
      vecs[2] = '{din: {85{2'b10}}, busy_at: -1, rst_at: 100, exp_edges: 100, exp_loads: 0};
      vecs[3] = '{din: {W{1'b1}}, busy_at: -1, rst_at: -1, exp_edges: W, exp_loads: LOAD_EN};

      // Reset held two cycles with start low.
      rst = 1'b1; start = 1'b0;
      for (int j = 0; j < 2; j++) begin
         @(posedge clk); @(negedge clk);
         chk("reset", j, {data_out, clk_sr, load_sr, count_delay}, '0);
      end
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); @(negedge clk);
         chk("idle", j, {data_out, clk_sr, load_sr, count_delay}, '0);
      end

      for (int v = 0; v < 4; v++) begin
         do_xfer($sformatf("vec%0d", v), vecs[v].din, vecs[v].busy_at, vecs[v].rst_at,
                 1'b0, 1'b0, '0, edges, loads);
         chk_int($sformatf("vec%0d_edges", v), edges, vecs[v].exp_edges);
         chk_int($sformatf("vec%0d_loads", v), loads, vecs[v].exp_loads);
         repeat (3) @(negedge clk);
      end

      // Start held high: next transfer accepted on the first idle cycle after LOAD.
      pat = {W/2{2'b01}};
      pat[W-1] = 1'b1;
      do_xfer("held_a", vecs[0].din, -1, -1, 1'b0, 1'b1, pat, edges, loads);
      chk_int("held_a_edges", edges, W);
      do_xfer("held_b", pat, -1, -1, 1'b1, 1'b0, '0, edges, loads);
      chk_int("held_b_edges", edges, W);
      chk_int("held_b_loads", loads, LOAD_EN);

      // Reset while start is high must win over start.
      @(negedge clk); rst = 1'b1; start = 1'b1; din = {W{1'b1}};
      @(posedge clk); @(negedge clk); rst = 1'b0; start = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); @(negedge clk);
         chk("rst_prio", j, {data_out, clk_sr, load_sr, count_delay}, '0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/sr_control.md
SR_CONTROL -- requirements
Module: sr_control

Interface
REQ-001 Parameter WIDTH, default 170: number of bits serialized per transfer.
REQ-002 Parameter CNT_WIDTH, default 8: width of the bit counter; SHALL satisfy 2^CNT_WIDTH > WIDTH.
REQ-003 clk  input  1: single system clock; all logic on rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 start  input  1: transfer request, sampled only in IDLE.
REQ-006 din  input  WIDTH: parallel word to serialize, captured when start is accepted.
REQ-007 data_out  output  1: serial data to external shift register, MSB first.
REQ-008 clk_sr  output  1: shift clock to external shift register; data_out stable across its rising edge.
REQ-009 load_sr  output  1: one-cycle load/latch strobe after the last bit.
REQ-010 count_delay  output  CNT_WIDTH: number of bits fully shifted in the current transfer.

Function
REQ-011 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-012 States: IDLE, SHIFT_LO, SHIFT_HI, LOAD.
REQ-013 IDLE: data_out=0, clk_sr=0, load_sr=0, count_delay=0; start=1 at edge E0 -> capture din into internal shift register, go to SHIFT_LO.
REQ-014 SHIFT_LO (one cycle): clk_sr=0, data_out=current MSB of internal shift register -> SHIFT_HI.
REQ-015 SHIFT_HI (one cycle): clk_sr=1, data_out unchanged; on exit, shift register shifts left by 1 and count_delay increments by 1.
REQ-016 Exit of SHIFT_HI with count_delay==WIDTH-1 (last bit) -> LOAD; otherwise -> SHIFT_LO.
REQ-017 Timing: bit i (i=0..WIDTH-1, i=0 is din[WIDTH-1]) appears on data_out after edge E(2i+1); clk_sr high after edge E(2i+2), low after E(2i+3).
REQ-018 LOAD (one cycle, after edge E(2*WIDTH+1)): clk_sr=0, data_out=0, load_sr=1, count_delay=WIDTH -> IDLE.
REQ-019 Total transfer: 2*WIDTH+2 cycles from start acceptance to return to IDLE.
REQ-020 start while not in IDLE SHALL be ignored; din changes after capture SHALL not affect the transfer.
REQ-021 start held high continuously SHALL begin a new transfer on the first IDLE cycle after LOAD.
REQ-022 count_delay SHALL never wrap within a transfer (max value WIDTH).

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, data_out=0, clk_sr=0, load_sr=0, count_delay=0, internal shift register=0.
REQ-024 rst mid-transfer SHALL abort without emitting load_sr; rst has priority over start.

Configuration
REQ-025 Macro SR_LOAD_STROBE_EN: defined -> load_sr behaves per REQ-018; undefined -> load_sr tied to 0, LOAD state still occupies one cycle (timing unchanged).

Verification
REQ-026 Reset: rst=1 for 2 cycles, start=0 -> all outputs 0, count_delay=0.
REQ-027 Basic transfer (WIDTH=170): din={1'b1,169'b1011}, start pulse one cycle -> serial sequence 1, then 165 zeros, then 1,0,1,1; 170 clk_sr rising edges; load_sr high exactly one cycle, 341 cycles after start sample; count_delay=170 during load_sr.
REQ-028 Sampling: at every clk_sr rising edge data_out equals expected bit; data_out changes only while clk_sr=0.
REQ-029 Busy start: second start pulse at bit 50 -> ignored; sequence and load_sr timing identical to REQ-027.
REQ-030 Reset mid-transfer: rst at bit 100 -> outputs 0 next cycle, no load_sr; subsequent start performs full correct transfer.
REQ-031 Macro off: repeat REQ-027 without SR_LOAD_STROBE_EN -> load_sr stays 0, serial data and clk_sr unchanged.
